alu_writeback_stage: RTL and testbench

ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

---
 rtl/alu_writeback_stage_pkg.sv | 49 ++++
 rtl/wb_fifo2.sv | 77 +++++++
 rtl/alu_writeback_stage.sv | 116 +++++++++++
 tb/tb_alu_writeback_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared definitions for the ALU writeback stage.
//   - opClass_t    : op-class encoding carried alongside each ALU result
//   - RSTATUS_*    : status codes written to the rstatus register on overflow
//   - WB_DEPTH     : number of buffered writeback entries
//   - wbEntry_t    : one formed writeback entry as stored in the buffer
package alu_writeback_stage_pkg;

   typedef enum logic [2:0] {
      OpAdd   = 3'd0,
      OpAddi  = 3'd1,
      OpSub   = 3'd2,
      OpBne   = 3'd3,
      OpBlt   = 3'd4,
      OpLogic = 3'd5,
      OpNop   = 3'd6
   } opClass_t;

   localparam logic [4:0]  RSTATUS_REG  = 5'd30;
   localparam logic [31:0] RSTATUS_ADD  = 32'd1;
   localparam logic [31:0] RSTATUS_ADDI = 32'd2;
   localparam logic [31:0] RSTATUS_SUB  = 32'd3;

   localparam int unsigned WB_DEPTH = 2;
   localparam int unsigned WB_CNT_W = $clog2(WB_DEPTH + 1);

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        brTaken;
      logic [31:0] brTarget;
      logic        isOvf;     // entry reports an arithmetic overflow
   } wbEntry_t;

   localparam int unsigned WB_ENTRY_W = $bits(wbEntry_t);

   // Status code reported for an overflowing arithmetic op.
   function automatic logic [31:0] rstatusCode(input opClass_t op);
      logic [31:0] code;
      case (op)
         OpAdd:   code = RSTATUS_ADD;
         OpAddi:  code = RSTATUS_ADDI;
         OpSub:   code = RSTATUS_SUB;
         default: code = '0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO with flush, holding formed writeback entries.
// Ports:
//   clock, reset    : clock and asynchronous active-high reset
//   flush           : clears all entries; a same-cycle push is discarded
//   pushValid/Ready : write handshake, pushReady depends only on registered count
//   pushEntry       : entry written on push
//   popValid/Ready  : read handshake, popValid = (count > 0)
//   popEntry        : oldest entry, stable while not popped
module wb_fifo2
   import alu_writeback_stage_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  pushValid,
   output logic                  pushReady,
   input  logic [WB_ENTRY_W-1:0] pushEntry,
   output logic                  popValid,
   input  logic                  popReady,
   output logic [WB_ENTRY_W-1:0] popEntry
);

   localparam logic [WB_CNT_W-1:0] CntDepth = WB_CNT_W'(WB_DEPTH);
   localparam logic [WB_CNT_W-1:0] CntOne   = WB_CNT_W'(1);

   logic [WB_CNT_W-1:0]   countQ, countD;
   logic [WB_ENTRY_W-1:0] slot0Q, slot0D;   // head (oldest)
   logic [WB_ENTRY_W-1:0] slot1Q, slot1D;
   logic                  push, pop;

   assign pushReady = (countQ < CntDepth);
   assign popValid  = (countQ != '0);
   assign popEntry  = slot0Q;

   assign push = pushValid && pushReady;
   assign pop  = popValid && popReady;

   always_comb begin
      countD = countQ;
      slot0D = slot0Q;
      slot1D = slot1Q;
      if (flush) begin
         countD = '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (countQ == '0) slot0D = pushEntry;
               else              slot1D = pushEntry;
               countD = countQ + CntOne;
            end
            2'b01: begin
               slot0D = slot1Q;
               countD = countQ - CntOne;
            end
            // Push and pop together only happen with one entry held, since a full
            // buffer refuses pushes: the new entry replaces the head in place.
            2'b11: begin
               slot0D = pushEntry;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         countQ <= '0;
         slot0Q <= '0;
         slot1Q <= '0;
      end else begin
         countQ <= countD;
         slot0Q <= slot0D;
         slot1Q <= slot1D;
      end
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: turns raw ALU results into register-write / branch
// entries, buffers them two deep, and retires them in order downstream.
// Ports:
//   clock, reset                  : clock and asynchronous active-high reset
//   in_valid / in_ready           : upstream handshake for one ALU result
//   in_result, in_isNotEqual,
//   in_isLessThan, in_overflow    : raw ALU outputs
//   in_op                         : op class (opClass_t encoding)
//   in_rd, in_br_target           : destination register and branch target
//   out_valid / out_ready         : downstream handshake
//   out_wen, out_rd, out_data     : register write of the oldest entry
//   out_br_taken, out_br_target   : branch outcome of the oldest entry
//   exc_count                     : saturating count of retired overflow entries
module alu_writeback_stage
   import alu_writeback_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_result,
   input  logic        in_isNotEqual,
   input  logic        in_isLessThan,
   input  logic        in_overflow,
   input  logic [2:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_br_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_wen,
   output logic [4:0]  out_rd,
   output logic [31:0] out_data,
   output logic        out_br_taken,
   output logic [31:0] out_br_target,
   output logic [15:0] exc_count
);

   wbEntry_t              newEntry;
   wbEntry_t              headEntry;
   logic [WB_ENTRY_W-1:0] headBits;
   logic                  headValid;
   logic                  popFire;
   logic                  flush;
   logic [15:0]           excCountQ, excCountD;

   // Entry formation from the raw ALU outputs.
   always_comb begin
      newEntry          = '0;
      newEntry.brTarget = in_br_target;
      case (opClass_t'(in_op))
         OpAdd, OpAddi, OpSub: begin
            newEntry.wen = 1'b1;
            if (in_overflow) begin
               newEntry.rd    = RSTATUS_REG;
               newEntry.data  = rstatusCode(opClass_t'(in_op));
               newEntry.isOvf = 1'b1;
            end else begin
               newEntry.rd   = in_rd;
               newEntry.data = in_result;
            end
         end
         OpLogic: begin
            newEntry.wen  = 1'b1;
            newEntry.rd   = in_rd;
            newEntry.data = in_result;
         end
         OpBne:   newEntry.brTaken = in_isNotEqual;
         OpBlt:   newEntry.brTaken = in_isLessThan;
         default: ;   // NOP and unused encodings: no write, no branch
      endcase
      // r0 is hardwired; never report a write to it.
      if (newEntry.rd == '0) newEntry.wen = 1'b0;
   end

   wb_fifo2 u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .pushValid (in_valid),
      .pushReady (in_ready),
      .pushEntry (newEntry),
      .popValid  (headValid),
      .popReady  (out_ready),
      .popEntry  (headBits)
   );

   assign headEntry = wbEntry_t'(headBits);
   assign popFire   = headValid && out_ready;
   // A retiring taken branch squashes everything younger, including a same-cycle push.
   assign flush     = popFire && headEntry.brTaken;

   // Fields are zeroed while empty so reset forces all outputs low at once.
   always_comb begin
      out_valid     = headValid;
      out_wen       = headValid & headEntry.wen;
      out_rd        = headValid ? headEntry.rd       : '0;
      out_data      = headValid ? headEntry.data     : '0;
      out_br_taken  = headValid & headEntry.brTaken;
      out_br_target = headValid ? headEntry.brTarget : '0;
   end

   always_comb begin
      excCountD = excCountQ;
      if (popFire && headEntry.isOvf && (excCountQ != 16'hFFFF)) begin
         excCountD = excCountQ + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) excCountQ <= '0;
      else       excCountQ <= excCountD;
   end

   assign exc_count = excCountQ;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: accepted pushes queue their
// hand-computed entries; a negedge monitor compares every retired entry.
module tb_alu_writeback_stage;
   import alu_writeback_stage_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] in_result;
   logic        in_isNotEqual, in_isLessThan, in_overflow;
   logic [2:0]  in_op;
   logic [4:0]  in_rd;
   logic [31:0] in_br_target;
   logic        out_valid, out_ready;
   logic        out_wen;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic        out_br_taken;
   logic [31:0] out_br_target;
   logic [15:0] exc_count;

   alu_writeback_stage dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_isNotEqual (in_isNotEqual),
      .in_isLessThan (in_isLessThan),
      .in_overflow   (in_overflow),
      .in_op         (in_op),
      .in_rd         (in_rd),
      .in_br_target  (in_br_target),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_wen       (out_wen),
      .out_rd        (out_rd),
      .out_data      (out_data),
      .out_br_taken  (out_br_taken),
      .out_br_target (out_br_target),
      .exc_count     (exc_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        brTaken;
      logic [31:0] brTarget;
   } expEntry_t;

   expEntry_t expQ[$];
   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int flushCyc = -1;
   int nPops    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   function automatic expEntry_t mk(input logic wen, input logic [4:0] rd, input logic [31:0] data,
                                    input logic bt, input logic [31:0] tgt);
      expEntry_t e;
      e.wen = wen; e.rd = rd; e.data = data; e.brTaken = bt; e.brTarget = tgt;
      return e;
   endfunction

   // Monitor: a pop happens at the coming posedge when valid and ready are high now.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         nPops++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got rd=%0d data=0x%08h wen=%0b bt=%0b, required no entry",
                     out_rd, out_data, out_wen, out_br_taken);
         end else begin
            expEntry_t e;
            e = expQ.pop_front();
            check("pop_wen", 32'(out_wen), 32'(e.wen));
            check("pop_br_taken", 32'(out_br_taken), 32'(e.brTaken));
            if (e.wen) begin
               check("pop_rd", 32'(out_rd), 32'(e.rd));
               check("pop_data", out_data, e.data);
            end
            if (e.brTaken) begin
               check("pop_br_target", out_br_target, e.brTarget);
               expQ.delete();
               flushCyc = cyc;
            end
         end
      end
   end

   // Drive one ALU result until accepted; queue its expectation unless flushed the same cycle.
   task automatic pushOp(input logic [2:0] op, input logic [31:0] res, input logic ne,
                         input logic lt, input logic ovf, input logic [4:0] rd,
                         input logic [31:0] tgt, input expEntry_t e);
      bit done = 0;
      int acceptCyc = 0;
      in_op = op; in_result = res; in_isNotEqual = ne; in_isLessThan = lt;
      in_overflow = ovf; in_rd = rd; in_br_target = tgt; in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (in_ready) begin
            done = 1;
            acceptCyc = cyc;
         end
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got in_ready=0 for 50 cycles, required acceptance");
      end else if (acceptCyc != flushCyc) begin
         expQ.push_back(e);
      end
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 20 && (expQ.size() != 0 || out_valid); i++) begin
         @(posedge clock);
         #1;
      end
      check(name, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int popsBefore;
      reset = 1'b1;
      in_valid = 0; in_result = 0; in_isNotEqual = 0; in_isLessThan = 0;
      in_overflow = 0; in_op = 0; in_rd = 0; in_br_target = 0; out_ready = 0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_exc_count", 32'(exc_count), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Simple ADD, 1-cycle latency.
      out_ready = 1'b1;
      pushOp(OpAdd, 32'h7, 0, 0, 0, 5'd5, 32'h0, mk(1, 5'd5, 32'h7, 0, 0));
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_wen", 32'(out_wen), 32'd1);
      check("add_rd", 32'(out_rd), 32'd5);
      check("add_data", out_data, 32'h7);
      @(posedge clock);
      #1;

      // SUB overflow -> rstatus write, exc_count after the pop.
      pushOp(OpSub, 32'h1234, 0, 0, 1, 5'd9, 32'h0, mk(1, 5'd30, 32'd3, 0, 0));
      check("ovf_rd", 32'(out_rd), 32'd30);
      @(posedge clock);
      #1;
      check("ovf_exc_count", 32'(exc_count), 32'd1);

      // Assorted op classes streaming through.
      pushOp(OpLogic, 32'hA5A50000, 0, 0, 0, 5'd12, 32'h0, mk(1, 5'd12, 32'hA5A50000, 0, 0));
      pushOp(OpAdd,   32'h99, 0, 0, 0, 5'd0, 32'h0, mk(0, 5'd0, 32'h0, 0, 0));
      pushOp(OpBlt,   32'h0, 1, 0, 0, 5'd3, 32'h44, mk(0, 5'd0, 32'h0, 0, 0));
      pushOp(OpNop,   32'h5, 0, 0, 1, 5'd4, 32'h0, mk(0, 5'd0, 32'h0, 0, 0));
      pushOp(OpAddi,  32'hFFFF, 0, 0, 1, 5'd7, 32'h0, mk(1, 5'd30, 32'd2, 0, 0));
      pushOp(OpLogic, 32'h0F0F, 0, 0, 1, 5'd2, 32'h0, mk(1, 5'd2, 32'h0F0F, 0, 0));
      pushOp(OpBne,   32'h0, 0, 1, 0, 5'd1, 32'h48, mk(0, 5'd0, 32'h0, 0, 0));
      pushOp(OpAddi,  32'hDEADBEEF, 0, 0, 0, 5'd31, 32'h0, mk(1, 5'd31, 32'hDEADBEEF, 0, 0));
      waitDrain("mix_drain");
      check("mix_exc_count", 32'(exc_count), 32'd2);

      // Backpressure: third push stalls until downstream drains.
      out_ready = 1'b0;
      pushOp(OpAdd, 32'h100, 0, 0, 0, 5'd1, 32'h0, mk(1, 5'd1, 32'h100, 0, 0));
      pushOp(OpAdd, 32'h200, 0, 0, 0, 5'd2, 32'h0, mk(1, 5'd2, 32'h200, 0, 0));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_head", out_data, 32'h100);
      fork
         pushOp(OpAdd, 32'h300, 0, 0, 0, 5'd3, 32'h0, mk(1, 5'd3, 32'h300, 0, 0));
         begin
            repeat (2) @(posedge clock);
            #1;
            check("bp_hold_data", out_data, 32'h100);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
         end
      join
      waitDrain("bp_drain");

      // Flush with two entries; the stalled push lands after the flush.
      out_ready = 1'b0;
      pushOp(OpBne, 32'h0, 1, 0, 0, 5'd0, 32'h40, mk(0, 5'd0, 32'h0, 1, 32'h40));
      pushOp(OpAdd, 32'h55, 0, 0, 0, 5'd6, 32'h0, mk(1, 5'd6, 32'h55, 0, 0));
      out_ready = 1'b1;
      fork
         pushOp(OpAdd, 32'h66, 0, 0, 0, 5'd8, 32'h0, mk(1, 5'd8, 32'h66, 0, 0));
         begin
            @(posedge clock);
            #1;
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_in_ready", 32'(in_ready), 32'd1);
         end
      join
      waitDrain("flush_drain");

      // Flush with one entry discards the same-cycle push.
      out_ready = 1'b0;
      pushOp(OpBlt, 32'h0, 0, 1, 0, 5'd3, 32'h80, mk(0, 5'd0, 32'h0, 1, 32'h80));
      out_ready = 1'b1;
      pushOp(OpAdd, 32'h77, 0, 0, 0, 5'd4, 32'h0, mk(1, 5'd4, 32'h77, 0, 0));
      check("discard_out_valid", 32'(out_valid), 32'd0);
      repeat (3) @(posedge clock);
      #1;
      check("discard_idle", 32'(out_valid), 32'd0);
      check("discard_queue", 32'(expQ.size()), 32'd0);

      // Reset with two entries buffered.
      out_ready = 1'b0;
      pushOp(OpAdd, 32'h10, 0, 0, 0, 5'd1, 32'h0, mk(1, 5'd1, 32'h10, 0, 0));
      pushOp(OpSub, 32'h20, 0, 0, 1, 5'd2, 32'h0, mk(1, 5'd30, 32'd3, 0, 0));
      check("rmid_full", 32'(in_ready), 32'd0);
      popsBefore = nPops;
      #2;
      reset = 1'b1;
      expQ.delete();
      #1;
      check("rmid_out_valid", 32'(out_valid), 32'd0);
      check("rmid_in_ready", 32'(in_ready), 32'd1);
      check("rmid_out_wen", 32'(out_wen), 32'd0);
      check("rmid_out_rd", 32'(out_rd), 32'd0);
      check("rmid_out_data", out_data, 32'd0);
      check("rmid_out_br", 32'(out_br_taken), 32'd0);
      check("rmid_out_tgt", out_br_target, 32'd0);
      check("rmid_exc_count", 32'(exc_count), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rmid_no_pop", 32'(nPops), 32'(popsBefore));
      check("rmid_idle", 32'(out_valid), 32'd0);

      // Saturation of exc_count.
      for (int i = 0; i < 65535; i++) begin
         pushOp(OpAdd, 32'h0, 0, 0, 1, 5'd1, 32'h0, mk(1, 5'd30, 32'd1, 0, 0));
      end
      waitDrain("sat_drain");
      check("sat_reach", 32'(exc_count), 32'hFFFF);
      pushOp(OpAdd, 32'h0, 0, 0, 1, 5'd1, 32'h0, mk(1, 5'd30, 32'd1, 0, 0));
      waitDrain("sat_drain2");
      check("sat_hold", 32'(exc_count), 32'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
